// File: rtl/account_arbiter.sv
// Round-robin arbiter that applies deposit/withdrawal transactions from NUM_REQ
// requesters to one shared 64-bit balance. Optional withdrawal cap: `ACCT_LIMIT_EN.
module account_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [63:0] INIT_BALANCE = 64'h917F_9BED_5ADB_6DFD,
    parameter logic [31:0] MAX_WITHDRAW = 32'd100000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     trans_type,
    input  logic [32*NUM_REQ-1:0]  amount,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   done,
    output logic [1:0]             status,
    output logic [63:0]            balance
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_LIMIT = 2'b11;

`ifdef ACCT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               done_q;
    logic [1:0]         status_q;
    logic [63:0]        balance_q;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   win_q;
    logic               type_q;
    logic [31:0]        amt_q;

    logic [31:0]        amt_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_amt
            assign amt_arr[gi] = amount[32*gi +: 32];
        end
    endgenerate

    // First requesting index at or after rr_q, wrapping around.
    logic [IDX_W-1:0] win_d;
    logic [IDX_W-1:0] scan_idx;
    logic             found_d;

    always_comb begin
        win_d    = '0;
        found_d  = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found_d && req[scan_idx]) begin
                found_d = 1'b1;
                win_d   = scan_idx;
            end
        end
    end

    logic [63:0] amt64;
    logic [64:0] sum_d;
    logic        limit_hit;
    logic [63:0] balance_d;
    logic [1:0]  status_d;
    logic [IDX_W-1:0] rr_d;

    always_comb begin
        amt64     = {32'd0, amt_q};
        sum_d     = {1'b0, balance_q} + {1'b0, amt64};
        limit_hit = LIMIT_EN && (amt_q > MAX_WITHDRAW);
        balance_d = balance_q;
        status_d  = ST_OK;
        if (!type_q) begin
            if (sum_d[64]) begin
                status_d = ST_OVF;
            end else begin
                balance_d = sum_d[63:0];
            end
        end else if (limit_hit) begin
            status_d = ST_LIMIT;
        end else if (amt64 > balance_q) begin
            status_d = ST_INSUF;
        end else begin
            balance_d = balance_q - amt64;
        end
    end

    assign rr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            done_q    <= 1'b0;
            status_q  <= ST_OK;
            balance_q <= INIT_BALANCE;
            rr_q      <= '0;
            win_q     <= '0;
            type_q    <= 1'b0;
            amt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        type_q  <= trans_type[win_d];
                        amt_q   <= amt_arr[win_d];
                        win_q   <= win_d;
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    balance_q <= balance_d;
                    status_q  <= status_d;
                    done_q    <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    grant_q <= '0;
                    done_q  <= 1'b0;
                    rr_q    <= rr_d;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign status  = status_q;
    assign balance = balance_q;

endmodule

// File: tb/tb_account_arbiter.sv
// Scoreboard bench for account_arbiter: three instances with different initial
// balances share one stimulus stream; a reference model predicts every done.
module tb_account_arbiter;
    localparam int          N      = 4;
    localparam logic [31:0] MAXW   = 32'd100000;
    localparam logic [63:0] INIT_A = 64'h917F_9BED_5ADB_6DFD;
    localparam logic [63:0] INIT_B = 64'd1000;
    localparam logic [63:0] INIT_C = 64'hFFFF_FFFF_FFFF_FFF0;
`ifdef ACCT_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   trans_type;
    logic [127:0] amount;

    logic [3:0]   grant_w   [3];
    logic         done_w    [3];
    logic [1:0]   status_w  [3];
    logic [63:0]  balance_w [3];

    always #5 clock = ~clock;

    account_arbiter #(.NUM_REQ(N), .INIT_BALANCE(INIT_A), .MAX_WITHDRAW(MAXW)) dut_a (
        .clock(clock), .reset(reset), .req(req), .trans_type(trans_type), .amount(amount),
        .grant(grant_w[0]), .done(done_w[0]), .status(status_w[0]), .balance(balance_w[0]));
    account_arbiter #(.NUM_REQ(N), .INIT_BALANCE(INIT_B), .MAX_WITHDRAW(MAXW)) dut_b (
        .clock(clock), .reset(reset), .req(req), .trans_type(trans_type), .amount(amount),
        .grant(grant_w[1]), .done(done_w[1]), .status(status_w[1]), .balance(balance_w[1]));
    account_arbiter #(.NUM_REQ(N), .INIT_BALANCE(INIT_C), .MAX_WITHDRAW(MAXW)) dut_c (
        .clock(clock), .reset(reset), .req(req), .trans_type(trans_type), .amount(amount),
        .grant(grant_w[2]), .done(done_w[2]), .status(status_w[2]), .balance(balance_w[2]));

    typedef struct packed {
        logic [3:0]        g;
        logic [2:0][1:0]   st;
        logic [2:0][63:0]  bal;
    } exp_t;

    typedef struct packed {
        logic [3:0]        g1, g2, g3;
        logic              d1, d2, d3;
        logic [2:0][1:0]   st;
        logic [2:0][63:0]  bal;
    } obs_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_bal [3];
    logic [63:0] init_v  [3];
    int          rr_m;

    // Reference model: pick the winner, apply to every instance, queue the result.
    task automatic model_push(input logic [3:0] rq, input logic [3:0] tt, input logic [127:0] am);
        exp_t        e;
        int          w;
        logic [31:0] a;
        logic [64:0] s;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && rq[(rr_m + k) % N]) w = (rr_m + k) % N;
        if (w < 0) return;
        e.g = 4'b0001 << w;
        a   = am[32*w +: 32];
        for (int i = 0; i < 3; i++) begin
            e.st[i] = 2'b00;
            if (tt[w] == 1'b0) begin
                s = {1'b0, exp_bal[i]} + {33'd0, a};
                if (s[64]) e.st[i] = 2'b10;
                else       exp_bal[i] = s[63:0];
            end else if (LIMIT_ON && a > MAXW) begin
                e.st[i] = 2'b11;
            end else if ({32'd0, a} > exp_bal[i]) begin
                e.st[i] = 2'b01;
            end else begin
                exp_bal[i] = exp_bal[i] - {32'd0, a};
            end
            e.bal[i] = exp_bal[i];
        end
        rr_m = (w + 1) % N;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req = '0; trans_type = '0; amount = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_bal[i] = init_v[i];
        rr_m = 0;
        sb.delete();
    endtask

    // Drives one single-requester transaction and samples EXEC, DONE and the cycle after.
    task automatic run_txn(input int r, input logic typ, input logic [31:0] amt, output obs_t o);
        @(negedge clock);
        req = '0; req[r] = 1'b1; trans_type[r] = typ; amount[32*r +: 32] = amt;
        model_push(req, trans_type, amount);
        @(negedge clock);
        o.g1 = grant_w[0]; o.d1 = done_w[0];
        @(negedge clock);
        o.g2 = grant_w[0]; o.d2 = done_w[0];
        for (int i = 0; i < 3; i++) begin
            o.st[i]  = status_w[i];
            o.bal[i] = balance_w[i];
        end
        req = '0;
        @(negedge clock);
        o.g3 = grant_w[0]; o.d3 = done_w[0];
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; req = '0; trans_type = '0; amount = '0;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (grant_w[i] !== 4'b0 || done_w[i] !== 1'b0 || status_w[i] !== 2'b00 || balance_w[i] !== init_v[i]) begin
                fails++;
                $display("FAIL reset[%0d]: got grant=%b done=%b status=%b bal=%h, expected 0000/0/00/%h",
                         i, grant_w[i], done_w[i], status_w[i], balance_w[i], init_v[i]);
            end
        end
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (grant_w[i] !== 4'b0 || done_w[i] !== 1'b0 || balance_w[i] !== init_v[i]) begin
                fails++;
                $display("FAIL idle_after_reset[%0d]: got grant=%b done=%b bal=%h", i, grant_w[i], done_w[i], balance_w[i]);
            end
        end
        for (int i = 0; i < 3; i++) exp_bal[i] = init_v[i];
        rr_m = 0;
        sb.delete();
        $display("[TB] reset checked");
    endtask

    task automatic test_deposit();
        int          r_t [3] = '{0, 2, 1};
        logic        t_t [3] = '{1'b0, 1'b0, 1'b0};
        logic [31:0] a_t [3] = '{32'd500, 32'd0, 32'hFFFF_FFFF};
        obs_t o;
        exp_t e;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            run_txn(r_t[n], t_t[n], a_t[n], o);
            e = sb.pop_front();
            tests++;
            if (o.g1 !== e.g || o.d1 !== 1'b0) begin fails++;
                $display("FAIL dep%0d_exec: grant=%b done=%b, expected grant=%b done=0", n, o.g1, o.d1, e.g); end
            tests++;
            if (o.g2 !== e.g || o.d2 !== 1'b1) begin fails++;
                $display("FAIL dep%0d_done: grant=%b done=%b, expected grant=%b done=1", n, o.g2, o.d2, e.g); end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (o.st[i] !== e.st[i] || o.bal[i] !== e.bal[i]) begin fails++;
                    $display("FAIL dep%0d_result[%0d]: status=%b bal=%h, expected %b %h", n, i, o.st[i], o.bal[i], e.st[i], e.bal[i]); end
            end
            tests++;
            if (o.g3 !== 4'b0 || o.d3 !== 1'b0) begin fails++;
                $display("FAIL dep%0d_release: grant=%b done=%b, expected 0000/0", n, o.g3, o.d3); end
            $display("[TB] deposit req=%0d amt=%h status=%b bal=%h", r_t[n], a_t[n], o.st[0], o.bal[0]);
        end
    endtask

    task automatic test_withdraw();
        int          r_t [3] = '{1, 2, 3};
        logic        t_t [3] = '{1'b1, 1'b1, 1'b1};
        logic [31:0] a_t [3] = '{32'd1000, 32'd1, 32'd0};
        obs_t o;
        exp_t e;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            run_txn(r_t[n], t_t[n], a_t[n], o);
            e = sb.pop_front();
            tests++;
            if (o.g1 !== e.g || o.d2 !== 1'b1 || o.g2 !== e.g || o.d1 !== 1'b0) begin fails++;
                $display("FAIL wd%0d_handshake: grant=%b/%b done=%b/%b, expected grant=%b done=0/1", n, o.g1, o.g2, o.d1, o.d2, e.g); end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (o.st[i] !== e.st[i] || o.bal[i] !== e.bal[i]) begin fails++;
                    $display("FAIL wd%0d_result[%0d]: status=%b bal=%h, expected %b %h", n, i, o.st[i], o.bal[i], e.st[i], e.bal[i]); end
            end
            tests++;
            if (o.g3 !== 4'b0 || o.d3 !== 1'b0) begin fails++;
                $display("FAIL wd%0d_release: grant=%b done=%b, expected 0000/0", n, o.g3, o.d3); end
            $display("[TB] withdraw req=%0d amt=%0d status(b)=%b bal(b)=%0d", r_t[n], a_t[n], o.st[1], o.bal[1]);
        end
    endtask

    task automatic test_overflow();
        int          r_t [3] = '{3, 0, 1};
        logic        t_t [3] = '{1'b0, 1'b0, 1'b0};
        logic [31:0] a_t [3] = '{32'h20, 32'hF, 32'd1};
        obs_t o;
        exp_t e;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            run_txn(r_t[n], t_t[n], a_t[n], o);
            e = sb.pop_front();
            tests++;
            if (o.g1 !== e.g || o.g2 !== e.g || o.d2 !== 1'b1) begin fails++;
                $display("FAIL ovf%0d_handshake: grant=%b/%b done=%b, expected grant=%b done=1", n, o.g1, o.g2, o.d2, e.g); end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (o.st[i] !== e.st[i] || o.bal[i] !== e.bal[i]) begin fails++;
                    $display("FAIL ovf%0d_result[%0d]: status=%b bal=%h, expected %b %h", n, i, o.st[i], o.bal[i], e.st[i], e.bal[i]); end
            end
            $display("[TB] overflow req=%0d amt=%h status(c)=%b bal(c)=%h", r_t[n], a_t[n], o.st[2], o.bal[2]);
        end
    endtask

    task automatic test_limit();
        int          r_t [2] = '{1, 2};
        logic        t_t [2] = '{1'b1, 1'b1};
        logic [31:0] a_t [2] = '{32'd100001, 32'd100000};
        obs_t o;
        exp_t e;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            run_txn(r_t[n], t_t[n], a_t[n], o);
            e = sb.pop_front();
            tests++;
            if (o.g2 !== e.g || o.d2 !== 1'b1) begin fails++;
                $display("FAIL lim%0d_handshake: grant=%b done=%b, expected grant=%b done=1", n, o.g2, o.d2, e.g); end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (o.st[i] !== e.st[i] || o.bal[i] !== e.bal[i]) begin fails++;
                    $display("FAIL lim%0d_result[%0d]: status=%b bal=%h, expected %b %h", n, i, o.st[i], o.bal[i], e.st[i], e.bal[i]); end
            end
            $display("[TB] limit amt=%0d status(a)=%b status(b)=%b", a_t[n], o.st[0], o.st[1]);
        end
    endtask

    task automatic test_round_robin();
        exp_t       e;
        int         cyc, ndone, ngr, last_start;
        logic [3:0] prev_g;
        do_reset();
        @(negedge clock);
        trans_type = 4'b0000;
        amount     = {32'd40, 32'd30, 32'd20, 32'd10};
        req        = 4'hF;
        for (int n = 0; n < 5; n++) model_push(req, trans_type, amount);
        cyc = 0; ndone = 0; ngr = 0; last_start = 0; prev_g = 4'b0;
        while (ndone < 5 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            tests++;
            if (!$onehot0(grant_w[0]) || (done_w[0] === 1'b1 && grant_w[0] === 4'b0)) begin fails++;
                $display("FAIL rr_onehot: grant=%b done=%b at cycle %0d", grant_w[0], done_w[0], cyc); end
            if (grant_w[0] !== 4'b0 && prev_g === 4'b0) begin
                if (ngr > 0) begin
                    tests++;
                    if (cyc - last_start != 3) begin fails++;
                        $display("FAIL rr_spacing: got %0d cycles between grants, expected 3", cyc - last_start); end
                end
                last_start = cyc;
                ngr++;
            end
            if (done_w[0] === 1'b1) begin
                ndone++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rr_extra_done: got done with grant=%b, expected no done", grant_w[0]);
                end else begin
                    e = sb.pop_front();
                    if (grant_w[0] !== e.g || status_w[0] !== e.st[0] || balance_w[0] !== e.bal[0]) begin fails++;
                        $display("FAIL rr_done%0d: grant=%b status=%b bal=%h, expected %b %b %h",
                                 ndone, grant_w[0], status_w[0], balance_w[0], e.g, e.st[0], e.bal[0]);
                    end
                end
                $display("[TB] rr done %0d grant=%b bal=%h", ndone, grant_w[0], balance_w[0]);
                if (ndone == 5) req = 4'b0;
            end
            prev_g = grant_w[0];
        end
        tests++;
        if (ndone != 5 || ngr != 5) begin fails++;
            $display("FAIL rr_count: got %0d grants %0d dones, expected 5 and 5", ngr, ndone); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++;
            if (grant_w[0] !== 4'b0 || done_w[0] !== 1'b0) begin fails++;
                $display("FAIL rr_quiet: grant=%b done=%b, expected 0000/0", grant_w[0], done_w[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clock);
        req = 4'b0001; trans_type = 4'b0000; amount = '0; amount[31:0] = 32'd500;
        @(negedge clock);
        tests++;
        if (grant_w[0] !== 4'b0001) begin fails++;
            $display("FAIL mid_grant: got %b, expected 0001", grant_w[0]); end
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (grant_w[i] !== 4'b0 || done_w[i] !== 1'b0 || balance_w[i] !== init_v[i]) begin fails++;
                $display("FAIL mid_reset[%0d]: grant=%b done=%b bal=%h, expected 0000/0/%h",
                         i, grant_w[i], done_w[i], balance_w[i], init_v[i]); end
        end
        reset = 1'b0; req = 4'b0;
        @(negedge clock);
        tests++;
        if (done_w[0] !== 1'b0 || balance_w[0] !== init_v[0]) begin fails++;
            $display("FAIL mid_after: done=%b bal=%h, expected 0/%h", done_w[0], balance_w[0], init_v[0]); end
        $display("[TB] reset in EXEC bal=%h", balance_w[0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; trans_type = '0; amount = '0;
        init_v[0] = INIT_A; init_v[1] = INIT_B; init_v[2] = INIT_C;
        rr_m = 0;
        test_reset();
        test_deposit();
        test_withdraw();
        test_overflow();
        test_limit();
        test_round_robin();
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin fails++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
